in_reg_bank_ctrl: RTL and testbench

Controller for a bank of `WIDTH` input-register cells on the AP3 I/O ring. It drives the cells' `rst`, `sel` and `hold` controls, sequences reset and settle, and samples the cell outputs at a programmable rate. Samples are delivered through a 2-entry valid/ready buffer, with drop and sample counters. It sits between the I/O cells and fabric logic that consumes the captured words.

---
 rtl/in_reg_bank_pkg.sv | 25 ++
 rtl/in_reg_bank_fifo2.sv | 53 +++++
 rtl/in_reg_bank_ctrl.sv | 171 +++++++++++++++++
 tb/tb_in_reg_bank_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_reg_bank_pkg.sv
// Shared types for the input-register bank controller:
// FSM state encoding and a saturating-increment helper.
package in_reg_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam int SEQ_W = 16;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/in_reg_bank_fifo2.sv
// Two-entry valid/ready buffer for captured words.
// Ports: push_i/data_i in, full_o/empty_o status, m_* pop side.
module in_reg_bank_fifo2
  import in_reg_bank_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         pop;
  logic         wr_en;

  assign empty_o   = (cnt_q == 2'd0);
  assign full_o    = (cnt_q == 2'd2);
  assign m_valid_o = !empty_o;
  assign m_data_o  = mem_q[rd_q];
  assign pop       = m_valid_o && m_ready_i;
  // A pop frees a slot in the same cycle, so a full buffer still accepts.
  assign wr_en     = push_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(wr_en) - 2'(pop);
    end
  end

endmodule

// File: rtl/in_reg_bank_ctrl.sv
// Input-register bank controller: cell reset/settle sequencing,
// divided-rate sampling into a 2-entry buffer, sample/drop counters.
// Ports: start/stop/cfg_* control, cell_* to the I/O cells,
// m_valid/m_ready/m_data stream out, busy and counters as status.
// Optional: IN_REG_BANK_BYPASS_EN enables the per-lane cell_sel bypass.
module in_reg_bank_ctrl
  import in_reg_bank_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16,
  parameter int DIV_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_bypass,
  input  logic [WIDTH-1:0] cell_data,
  output logic             cell_rst,
  output logic [WIDTH-1:0] cell_sel,
  output logic [WIDTH-1:0] cell_hold,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SET_LD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cdiv_q, cdiv_d;
  logic [CNT_W-1:0]   smp_q, smp_d;
  logic [CNT_W-1:0]   drp_q, drp_d;
  logic               push;
  logic               full;
  logic               empty;
  logic               pop;

  assign pop        = m_valid && m_ready;
  assign busy       = (state_q != ST_IDLE);
  assign cell_rst   = (state_q == ST_RESET);
  assign cell_hold  = {WIDTH{(state_q == ST_RUN) && full}};
  assign sample_cnt = smp_q;
  assign drop_cnt   = drp_q;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    div_d   = div_q;
    cdiv_d  = cdiv_q;
    smp_d   = smp_q;
    drp_d   = drp_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RESET;
          seq_d   = SEQ_W'(RST_CYCLES - 1);
          cdiv_d  = cfg_div;
          smp_d   = '0;
          drp_d   = '0;
        end
      end
      ST_RESET: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (seq_q == '0) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = ST_RUN;
            div_d   = '0;
          end else begin
            state_d = ST_SETTLE;
            seq_d   = SEQ_W'(SET_LD);
          end
        end else begin
          seq_d = seq_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (seq_q == '0) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          seq_d = seq_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (div_q == '0) begin
          push  = 1'b1;
          div_d = cdiv_q;
          if (full && !pop) begin
            drp_d = CNT_W'(sat_inc(64'(drp_q), CNT_W));
          end else begin
            smp_d = CNT_W'(sat_inc(64'(smp_q), CNT_W));
          end
        end else begin
          div_d = div_q - 1'b1;
        end
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      div_q   <= '0;
      cdiv_q  <= '0;
      smp_q   <= '0;
      drp_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      div_q   <= div_d;
      cdiv_q  <= cdiv_d;
      smp_q   <= smp_d;
      drp_q   <= drp_d;
    end
  end

`ifdef IN_REG_BANK_BYPASS_EN
  logic [WIDTH-1:0] byp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      byp_q <= cfg_bypass;
    end
  end

  assign cell_sel = busy ? byp_q : '0;
`else
  logic unused_bypass;
  assign unused_bypass = ^cfg_bypass;
  assign cell_sel      = '0;
`endif

  in_reg_bank_fifo2 #(
    .W (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .data_i    (cell_data),
    .full_o    (full),
    .empty_o   (empty),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data)
  );

endmodule

// File: tb/tb_in_reg_bank_ctrl.sv
// Self-checking bench for in_reg_bank_ctrl against a
// cycle-timestamp reference model with a queue-based buffer.
module tb_in_reg_bank_ctrl;

  localparam int W     = 8;
  localparam int RSTC  = 2;
  localparam int SETC  = 1;
  localparam int CNT_W = 6;
  localparam int DIV_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] cfg_div;
  logic [W-1:0]     cfg_bypass;
  logic [W-1:0]     cell_data;
  logic             cell_rst;
  logic [W-1:0]     cell_sel;
  logic [W-1:0]     cell_hold;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic             busy;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] drop_cnt;

  in_reg_bank_ctrl #(
    .WIDTH         (W),
    .RST_CYCLES    (RSTC),
    .SETTLE_CYCLES (SETC),
    .CNT_W         (CNT_W),
    .DIV_W         (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_div    (cfg_div),
    .cfg_bypass (cfg_bypass),
    .cell_data  (cell_data),
    .cell_rst   (cell_rst),
    .cell_sel   (cell_sel),
    .cell_hold  (cell_hold),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .sample_cnt (sample_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit incr_mode  = 1'b0;
  bit rand_ready = 1'b0;

  // Reference model state
  bit         sess  = 1'b0;
  bit         drain = 1'b0;
  int         t0    = 0;
  int         tfirst = 0;
  int         mdiv  = 0;
  int         scnt  = 0;
  int         dcnt  = 0;
  logic [W-1:0] mbyp = '0;
  logic [W-1:0] q [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model across one rising edge using cycle-c inputs.
  task automatic model_edge(input int c);
    bit pop;
    bit tk;
    if (rst) begin
      sess = 0; drain = 0; q.delete(); scnt = 0; dcnt = 0;
      return;
    end
    if (!sess) begin
      if (start) begin
        sess = 1; drain = 0; t0 = c;
        tfirst = c + 1 + RSTC + SETC;
        mdiv = int'(cfg_div); scnt = 0; dcnt = 0;
        mbyp = cfg_bypass;
      end
      return;
    end
    pop = (q.size() > 0) && m_ready;
    if (drain) begin
      if (q.size() == 0) sess = 0;
      if (pop) void'(q.pop_front());
      return;
    end
    if (c < tfirst) begin
      if (stop) sess = 0;
      return;
    end
    tk = ((c - tfirst) % (mdiv + 1)) == 0;
    if (pop) void'(q.pop_front());
    if (tk) begin
      if (q.size() < 2) begin
        q.push_back(cell_data);
        if (scnt < CMAX) scnt++;
      end else begin
        if (dcnt < CMAX) dcnt++;
      end
    end
    if (stop) drain = 1;
  endtask

  task automatic check_all(input int n);
    logic         e_rst;
    logic [W-1:0] e_hold;
    logic [W-1:0] e_sel;
    e_rst  = sess && (n - t0) >= 1 && (n - t0) <= RSTC;
    e_hold = (sess && !drain && n >= tfirst && q.size() == 2) ? '1 : '0;
`ifdef IN_REG_BANK_BYPASS_EN
    e_sel  = sess ? mbyp : '0;
`else
    e_sel  = '0;
`endif
    chk("busy", 64'(busy), 64'(sess));
    chk("cell_rst", 64'(cell_rst), 64'(e_rst));
    chk("cell_hold", 64'(cell_hold), 64'(e_hold));
    chk("cell_sel", 64'(cell_sel), 64'(e_sel));
    chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("m_data", 64'(m_data), 64'(q[0]));
    chk("sample_cnt", 64'(sample_cnt), 64'(scnt));
    chk("drop_cnt", 64'(drop_cnt), 64'(dcnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    #1;
    check_all(cyc);
    @(negedge clk);
    if (incr_mode) cell_data = cell_data + 1'b1;
    else cell_data = W'($urandom);
    if (rand_ready) m_ready = 1'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_and_wait(input int lim);
    int k;
    stop = 1'b1;
    step();
    stop = 1'b0;
    k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk("drain_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    int rsth;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_div = '0; cfg_bypass = 8'hA5; cell_data = '0;
    m_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_mdata", 64'(m_data), 64'(0));
    step();

    // Back-to-back sampling with incrementing data
    incr_mode = 1'b1;
    cell_data = '0;
    cfg_div = 8'd0;
    pulse_start();
    rsth = int'(cell_rst);
    repeat (14) begin
      step();
      rsth += int'(cell_rst);
    end
    chk("rst_len", 64'(rsth), 64'(RSTC));
    stop_and_wait(20);

    // Divide by 4: five samples in twenty run cycles
    incr_mode = 1'b0;
    cfg_div = 8'd3;
    pulse_start();
    repeat (3) step();
    repeat (20) step();
    chk("div4_cnt", 64'(sample_cnt), 64'(5));
    stop_and_wait(20);

    // Back-pressure: buffer fills, rest dropped
    cfg_div = 8'd0;
    pulse_start();
    repeat (3) step();
    m_ready = 1'b0;
    repeat (10) step();
    chk("drop8", 64'(drop_cnt), 64'(8));
    chk("hold_ff", 64'(cell_hold), 64'(8'hFF));
    m_ready = 1'b1;
    stop_and_wait(20);

    // Stop during cell reset
    pulse_start();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_rst_busy", 64'(busy), 64'(0));
    repeat (3) step();

    // Start and stop together in IDLE: session begins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", 64'(busy), 64'(1));
    rand_ready = 1'b1;
    repeat (30) step();
    stop_and_wait(200);
    rand_ready = 1'b0;
    m_ready = 1'b1;

    // Sample counter saturation
    cfg_div = 8'd0;
    pulse_start();
    repeat (80) step();
    chk("sat", 64'(sample_cnt), 64'(CMAX));
    stop_and_wait(20);

    // Random sessions
    for (int s = 0; s < 6; s++) begin
      cfg_div = DIV_W'($urandom_range(0, 3));
      cfg_bypass = W'($urandom);
      rand_ready = 1'b1;
      pulse_start();
      repeat ($urandom_range(2, 40)) step();
      stop_and_wait(200);
      rand_ready = 1'b0;
      m_ready = 1'b1;
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset in RUN with the buffer full
    cfg_div = 8'd0;
    pulse_start();
    repeat (4) step();
    m_ready = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run_mdata", 64'(m_data), 64'(0));
    m_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
